config_wr_arbiter: RTL and testbench

Shares the single write port of `config_reg_map` between several command sources, for example the Ethernet command parser, a power-on default loader and a debug UART. Each requester presents one register write; the block grants requesters round-robin and issues one `wr_cmd` pulse per transaction. It then waits for the map's `wr_valid`/`wr_err` response, or a timeout, and returns the status to the granted requester. Only one transaction is outstanding at a time.

---
 rtl/config_wr_pkg.sv | 19 +
 rtl/config_rr_pick.sv | 37 +++
 rtl/config_wr_arbiter.sv | 118 +++++++++++
 tb/tb_config_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_wr_pkg.sv
// rtl/config_wr_pkg.sv - shared widths, map error codes and FSM states for config_wr_arbiter
package config_wr_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_KEEP     = 2'b01;
    localparam logic [1:0] ERR_KEEP_LSB = 2'b10;
    localparam logic [1:0] ERR_ADDR     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/config_rr_pick.sv
// rtl/config_rr_pick.sv - combinational round-robin selector: first request strictly after ptr, wrapping
module config_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] above;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Requests above the pointer win; if none, wrap to the lowest request overall.
    always_comb begin
        above = '0;
        for (int i = 0; i < N; i++) begin
            above[i] = (i > int'(ptr));
        end
        masked = req & above;
        pool   = (|masked) ? masked : req;
        gnt    = '0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt = N'(1) << i;
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/config_wr_arbiter.sv
// rtl/config_wr_arbiter.sv - round-robin sharing of the config_reg_map write port, one write in flight
module config_wr_arbiter
    import config_wr_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RESP_TIMEOUT = 64,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W       = $clog2(RESP_TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_keep,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [1:0]                rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      wr_cmd,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]         wr_keep,
    input  logic                      wr_ready,
    input  logic                      wr_valid,
    input  logic [1:0]                wr_err
);

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;

    config_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            cnt         <= '0;
            gnt_oh      <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_err     <= ERR_NONE;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            wr_cmd      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_keep     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any && wr_ready) begin
                        wr_addr   <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        wr_data   <= req_data[pick_idx*DATA_W +: DATA_W];
                        wr_keep   <= req_keep[pick_idx*DATA_W +: DATA_W];
                        grant_id  <= pick_idx;
                        ptr       <= pick_idx;
                        gnt_oh    <= pick_gnt;
                        wr_cmd    <= 1'b1;
                        req_ready <= pick_gnt;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                // Map responses during the strobe cycle are deliberately not looked at.
                ST_ISSUE: begin
                    wr_cmd    <= 1'b0;
                    req_ready <= '0;
                    cnt       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wr_err != ERR_NONE || wr_valid) begin
                        rsp_err   <= wr_err;
                        rsp_valid <= gnt_oh;
                        state     <= ST_RESP;
                    end else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                        rsp_err     <= ERR_NONE;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= gnt_oh;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid   <= '0;
                    rsp_err     <= ERR_NONE;
                    rsp_timeout <= 1'b0;
                    cnt         <= '0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_wr_arbiter.sv
// tb/tb_config_wr_arbiter.sv - transaction-level model and scoreboard for config_wr_arbiter
module tb_config_wr_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int T  = 8;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*DW-1:0] req_keep = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [1:0]      rsp_err;
    logic            rsp_timeout;
    logic            busy;
    logic [IW-1:0]   grant_id;
    logic            wr_cmd;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   wr_keep;
    logic            wr_ready = 1'b0;
    logic            wr_valid = 1'b0;
    logic [1:0]      wr_err = 2'b00;

    config_wr_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .RESP_TIMEOUT (T)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_addr (req_addr), .req_data (req_data), .req_keep (req_keep),
        .req_ready (req_ready), .rsp_valid (rsp_valid), .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
        .busy (busy), .grant_id (grant_id),
        .wr_cmd (wr_cmd), .wr_addr (wr_addr), .wr_data (wr_data), .wr_keep (wr_keep),
        .wr_ready (wr_ready), .wr_valid (wr_valid), .wr_err (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          id;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] k;
        logic [1:0]  err;
        logic        to;
    } exp_t;

    exp_t cmdq[$];
    exp_t rspq[$];
    int   grants[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    // Requester side and reference-model state
    logic [N-1:0]  pend = '0;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [DW-1:0] pk [N];
    int   drop_id = -1;
    int   last = N - 1;
    int   free_at = 0;
    int   cur_cmd = 0;
    int   cur_r = 0;
    bit   in_txn = 0;
    int   n_dec = 0;
    int   sched_cyc = -1;
    logic sched_v = 1'b0;
    logic [1:0] sched_e = 2'b00;

    // Stimulus knobs
    bit   rst_req = 1;
    bit   force_all = 0;
    bit   rdy_low = 0;
    int   req_pct = 0;
    int   rdy_pct = 100;
    int   stray_pct = 10;
    bit   plan_forced = 1;
    int   f_d = 1;
    logic f_v = 1'b1;
    logic [1:0] f_e = 2'b00;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    endfunction

    task automatic post(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] k);
        pend[i] = 1'b1; pa[i] = a; pd[i] = d; pk[i] = k;
    endtask

    task automatic step();
        int d;
        logic v;
        logic [1:0] er;
        exp_t e;
        int w;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = !rst_req;
        if (drop_id >= 0) begin
            pend[drop_id] = 1'b0;
            drop_id = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && (force_all || $urandom_range(99) < req_pct))
                post(i, AW'($urandom), $urandom, $urandom);
            req_valid[i] = pend[i];
            req_addr[i*AW +: AW] = pa[i];
            req_data[i*DW +: DW] = pd[i];
            req_keep[i*DW +: DW] = pk[i];
        end
        wr_ready = !rdy_low && ($urandom_range(99) < rdy_pct);
        wr_valid = 1'b0;
        wr_err = 2'b00;
        if (sched_cyc == cyc) begin
            wr_valid = sched_v;
            wr_err = sched_e;
        end else if (!(in_txn && cyc > cur_cmd && cyc < cur_r) && $urandom_range(99) < stray_pct) begin
            wr_valid = 1'($urandom_range(1));
            wr_err = 2'($urandom_range(3));
        end
        if (!rst_n) begin
            while (cmdq.size() > 0 && cmdq[cmdq.size()-1].cyc > cyc) void'(cmdq.pop_back());
            while (rspq.size() > 0 && rspq[rspq.size()-1].cyc > cyc) void'(rspq.pop_back());
            last = N - 1; free_at = cyc + 1; in_txn = 0; sched_cyc = -1;
        end else if (cyc >= free_at && wr_ready && pend != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && pend[(last + k) % N]) w = (last + k) % N;
            e.id = w; e.a = pa[w]; e.d = pd[w]; e.k = pk[w];
            e.cyc = cyc + 1; e.err = 2'b00; e.to = 1'b0;
            cmdq.push_back(e);
            if (plan_forced) begin
                d = f_d; v = f_v; er = f_e;
            end else begin
                d = $urandom_range(T + 2);
                case ($urandom_range(3))
                    0: begin v = 1'b0; er = 2'($urandom_range(3, 1)); end
                    1: begin v = 1'b1; er = 2'($urandom_range(3, 1)); end
                    default: begin v = 1'b1; er = 2'b00; end
                endcase
            end
            // A response inside the WAIT window wins; anything else ends in a timeout.
            if (d >= 1 && d <= T) begin
                e.err = er;
                e.cyc = cyc + 1 + d + 1;
            end else begin
                e.to = 1'b1;
                e.cyc = cyc + 1 + T + 1;
            end
            rspq.push_back(e);
            sched_cyc = cyc + 1 + d; sched_v = v; sched_e = er;
            cur_cmd = cyc + 1; cur_r = e.cyc; in_txn = 1;
            free_at = cur_r + 1; last = w; drop_id = w; n_dec++;
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    // Monitor: compares every cycle against whatever the model queued for it.
    int   last_cmd = -1;
    logic rst_prev = 1'b0;
    exp_t me;
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_prev) begin
                chk("reset_outputs", {wr_cmd, req_ready, rsp_valid, rsp_err, rsp_timeout, busy,
                                      grant_id, wr_addr, wr_data, wr_keep}, '0);
            end else begin
                if (cmdq.size() > 0 && cmdq[0].cyc == cyc) begin
                    me = cmdq.pop_front();
                    chk("cmd", {wr_cmd, req_ready, grant_id, busy, wr_addr, wr_data, wr_keep},
                        {1'b1, N'(1) << me.id, IW'(me.id), 1'b1, me.a, me.d, me.k});
                end else begin
                    chk("no_cmd", {wr_cmd, req_ready}, '0);
                end
                if (wr_cmd === 1'b1) begin
                    if (last_cmd >= 0) chk("cmd_spacing", 128'(cyc - last_cmd >= 4), 128'(1));
                    last_cmd = cyc;
                    grants.push_back(int'(grant_id));
                end
                if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
                    me = rspq.pop_front();
                    chk("rsp", {rsp_valid, rsp_err, rsp_timeout, grant_id, busy, wr_addr, wr_data, wr_keep},
                        {N'(1) << me.id, me.err, me.to, IW'(me.id), 1'b1, me.a, me.d, me.k});
                end else begin
                    chk("no_rsp", {rsp_valid, rsp_err, rsp_timeout}, '0);
                end
            end
            rst_prev = rst_n;
        end
    end

    initial begin
        int base;
        int g;
        for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; pk[i] = '0; end
        rst_req = 1; run(2); rst_req = 0;

        // Single write from requester 0, answered at the earliest slot
        plan_forced = 1; f_d = 1; f_v = 1'b1; f_e = 2'b00;
        post(0, 8'h05, 32'h14, 32'hFFFF_FFFF);
        run(8);

        // Contention from reset: strict alternation
        rst_req = 1; run(2); rst_req = 0;
        grants.delete();
        base = n_dec; force_all = 1;
        for (g = 0; g < 60 && n_dec < base + 6; g++) step();
        force_all = 0;
        run(20);
        chk("rr_count", 128'(grants.size() >= 6), 128'(1));
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", 128'(grants[i]), 128'(i % 2));

        // Error code together with wr_valid, then a clean write
        f_d = 1; f_v = 1'b1; f_e = 2'b11;
        post(1, 8'h3C, $urandom, $urandom);
        run(8);
        f_d = 2; f_v = 1'b1; f_e = 2'b00;
        post(0, 8'h11, $urandom, $urandom);
        run(10);

        // Timeout with a late wr_valid arriving after RESP
        f_d = T + 2; f_v = 1'b1; f_e = 2'b00;
        post(1, 8'h77, $urandom, $urandom);
        run(T + 10);

        // wr_ready held low with both requesters waiting
        f_d = 1;
        rdy_low = 1;
        post(0, 8'h21, $urandom, $urandom);
        post(1, 8'h22, $urandom, $urandom);
        run(20);
        rdy_low = 0;
        run(14);

        // Reset while a transaction sits in WAIT
        f_d = 0; f_v = 1'b0; f_e = 2'b00;
        base = n_dec;
        post(0, 8'h40, $urandom, $urandom);
        for (g = 0; g < 20 && n_dec == base; g++) step();
        run(3);
        rst_req = 1; run(2); rst_req = 0;
        f_d = 1; f_v = 1'b1;
        base = n_dec; force_all = 1;
        for (g = 0; g < 20 && n_dec < base + 1; g++) step();
        force_all = 0;
        run(12);

        // Randomized traffic with stray responses and random map behaviour
        plan_forced = 0; req_pct = 35; rdy_pct = 80; stray_pct = 15;
        run(1500);

        // Drain
        req_pct = 0; rdy_pct = 100; stray_pct = 0;
        for (g = 0; g < 300 && (cmdq.size() + rspq.size() > 0 || pend != '0 || cyc < free_at); g++) step();
        run(2);
        chk("drain_empty", 128'(cmdq.size() + rspq.size()), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
